// File: rtl/bch_link_checker.sv
// BCH link checker: LFSR frame generator feeding an encoder, plus a
// checker comparing decoded frames against a FIFO of reference frames.
module bch_link_checker #(
  parameter int          MSG_LEN   = 51,
  parameter int          REF_DEPTH = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic                 tx_data,
  input  logic                 rx_valid,
  input  logic                 rx_data,
  output logic [CNT_WIDTH-1:0] frames_sent,
  output logic [CNT_WIDTH-1:0] frames_ok,
  output logic [CNT_WIDTH-1:0] frames_bad,
  output logic [CNT_WIDTH-1:0] bit_errors,
  output logic                 frame_done,
  output logic                 frame_pass,
  output logic                 ref_underflow
);

  localparam int PW = (REF_DEPTH > 1) ? $clog2(REF_DEPTH) : 1;
  localparam int CW = $clog2(REF_DEPTH + 1);
  localparam int BW = $clog2(MSG_LEN);
  localparam int EW = 7;
  localparam int SW = CNT_WIDTH + EW;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } gen_state_t;

  gen_state_t state, state_nx;

  logic [15:0]        lfsr;
  logic               fb;
  logic [BW-1:0]      tx_cnt;
  logic [MSG_LEN-2:0] tx_sr;
  logic [MSG_LEN-1:0] tx_frame;
  logic               tx_fire;
  logic               tx_last;
  logic               can_start;

  logic [MSG_LEN-1:0] mem [REF_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      fill;
  logic               push;
  logic               pop;
  logic               have_ref;

  logic [BW-1:0]      rx_cnt;
  logic [MSG_LEN-2:0] rx_sr;
  logic [MSG_LEN-1:0] rx_frame;
  logic [MSG_LEN-1:0] diff;
  logic               rx_last;
  logic               match;
  logic [EW-1:0]      nerr;
  logic [SW-1:0]      err_wide;
  logic [CNT_WIDTH-1:0] err_sat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(REF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (v == CMAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign can_start = enable && (fill < CW'(REF_DEPTH));
  assign tx_valid  = (state == SEND);
  assign tx_data   = tx_valid & lfsr[0];
  assign tx_fire   = tx_valid && tx_ready;
  assign tx_last   = tx_fire && (tx_cnt == BW'(MSG_LEN - 1));
  assign tx_frame  = {tx_sr, lfsr[0]};
  // taps 16,14,13,11 of the right-shifting Fibonacci form
  assign fb        = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (can_start) state_nx = SEND;
      SEND:    if (tx_last) state_nx = HOLD;
      HOLD:    state_nx = can_start ? SEND : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      tx_cnt      <= '0;
      tx_sr       <= '0;
      frames_sent <= '0;
    end else begin
      state <= state_nx;
      if (state != SEND && state_nx == SEND) begin
        tx_cnt <= '0;
      end else if (tx_fire) begin
        tx_cnt <= tx_last ? '0 : tx_cnt + BW'(1);
      end
      if (tx_fire) begin
        lfsr  <= {fb, lfsr[15:1]};
        tx_sr <= tx_frame[MSG_LEN-2:0];
      end
      if (tx_last) frames_sent <= sat_inc(frames_sent);
    end
  end

  assign push     = tx_last;
  assign have_ref = (fill != '0);
  assign rx_last  = rx_valid && (rx_cnt == BW'(MSG_LEN - 1));
  assign pop      = rx_last && have_ref;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
    end
  end

  assign rx_frame = {rx_sr, rx_data};
  assign diff     = rx_frame ^ mem[rd_ptr];
  assign match    = have_ref && (diff == '0);

  always_comb begin
    nerr = '0;
    for (int i = 0; i < MSG_LEN; i++) nerr = nerr + EW'(diff[i]);
  end

  assign err_wide = SW'(bit_errors) + SW'(nerr);
  assign err_sat  = (err_wide > SW'(CMAX)) ? CMAX
                                            : err_wide[CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt        <= '0;
      rx_sr         <= '0;
      frame_done    <= 1'b0;
      frame_pass    <= 1'b0;
      frames_ok     <= '0;
      frames_bad    <= '0;
      bit_errors    <= '0;
      ref_underflow <= 1'b0;
    end else begin
      frame_done <= rx_last;
      frame_pass <= rx_last && match;
      if (rx_valid) begin
        rx_sr  <= rx_frame[MSG_LEN-2:0];
        rx_cnt <= rx_last ? '0 : rx_cnt + BW'(1);
      end
      if (rx_last) begin
        if (match) begin
          frames_ok <= sat_inc(frames_ok);
        end else begin
          frames_bad <= sat_inc(frames_bad);
          if (have_ref) bit_errors <= err_sat;
          else          ref_underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/bch_link_checker.md
BCH_LINK_CHECKER -- requirements
Module: bch_link_checker

Interface
REQ-001 The module SHALL declare these parameters: MSG_LEN, 51, bits per message frame (valid range 8..64).
REQ-002 The module SHALL declare parameter REF_DEPTH, 4, number of in-flight reference frames held (valid range 1..8).
REQ-003 The module SHALL declare parameter SEED, 16'hACE1, non-zero initial LFSR state.
REQ-004 The module SHALL declare parameter CNT_WIDTH, 16, width of all statistics counters.
REQ-005 The module SHALL have these ports:
  clk  in  1  single clock, all logic on its rising edge
  rst  in  1  synchronous, active-high reset
  enable  in  1  allow new frames to be generated
  tx_ready  in  1  downstream encoder accepts a bit
  tx_valid  out  1  tx_data holds a valid message bit
  tx_data  out  1  serial message bit, frame MSB first
  rx_valid  in  1  decoded bit present on rx_data
  rx_data  in  1  serial decoded bit, frame MSB first
  frames_sent  out  CNT_WIDTH  frames fully transmitted
  frames_ok  out  CNT_WIDTH  received frames matching reference
  frames_bad  out  CNT_WIDTH  received frames mismatching or unreferenced
  bit_errors  out  CNT_WIDTH  total mismatching bits
  frame_done  out  1  one-cycle pulse when a received frame is judged
  frame_pass  out  1  result of the judged frame, valid while frame_done=1
  ref_underflow  out  1  sticky: a frame was received with no reference stored

Function
REQ-006 Generator FSM SHALL have states IDLE, SEND, and HOLD.
REQ-007 IDLE->SEND SHALL occur when enable=1 and the reference FIFO holds fewer than REF_DEPTH entries; the tx bit counter SHALL be loaded with 0.
REQ-008 In SEND, tx_valid SHALL be 1; a bit SHALL transfer only on a cycle with tx_valid=1 and tx_ready=1.
REQ-009 tx_data SHALL be bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11); the LFSR SHALL advance exactly once per transferred bit and never otherwise.
REQ-010 Each transferred bit SHALL shift into a MSG_LEN-bit assembly register; on transfer of bit MSG_LEN-1, the assembled frame SHALL be pushed to the reference FIFO, frames_sent SHALL increment, and the FSM SHALL go to HOLD.
REQ-011 HOLD SHALL last one cycle with tx_valid=0, then go to SEND if the IDLE->SEND condition holds, otherwise to IDLE.
REQ-012 Deasserting enable mid-frame SHALL NOT truncate the frame; it takes effect only at the next frame boundary.
REQ-013 The checker SHALL shift rx_data into a MSG_LEN-bit register on each rx_valid=1 cycle, independently of the generator.
REQ-014 On the rx_valid cycle carrying bit MSG_LEN-1, the checker SHALL compare against the FIFO head, pop it, and in the next cycle pulse frame_done=1 with frame_pass=1 iff all bits are equal.
REQ-015 A mismatch SHALL increment frames_bad and add the popcount of (received XOR reference) to bit_errors; a match SHALL increment frames_ok.
REQ-016 If the FIFO is empty at frame completion, frames_bad SHALL increment, bit_errors SHALL be unchanged, ref_underflow SHALL set, and frame_pass SHALL be 0.
REQ-017 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-018 The FIFO SHALL use wrap-around pointers modulo REF_DEPTH; a push SHALL never occur while the FIFO is full, which is guaranteed by REQ-007.
REQ-019 All counters SHALL saturate at all-ones; a bit_errors addition that would exceed the maximum SHALL clamp to the maximum.
REQ-020 frame_pass SHALL be 0 whenever frame_done=0.

Reset
REQ-021 When rst=1 at a clock edge, the following SHALL be restored: generator state IDLE, LFSR=SEED, bit counters 0, FIFO empty, all counters 0, ref_underflow 0, and tx_valid, tx_data, frame_done and frame_pass all 0.
REQ-022 Reset asserted mid-frame SHALL discard both partial frames; after release, the first frame SHALL restart from SEED.
REQ-023 During reset, tx_valid SHALL remain 0 regardless of enable.

Verification
REQ-024 Loopback scenario: enable=1, tx_ready=1, rx driven from tx delayed 10 cycles, run 5 frames -> frames_sent=5, frames_ok=5, frames_bad=0, bit_errors=0, five frame_done pulses each with frame_pass=1.
REQ-025 Error-injection scenario: loopback with bits 3 and 40 of frame 2 inverted -> frames_ok=4, frames_bad=1, bit_errors=2, and frame_pass=0 on the second pulse only.
REQ-026 Backpressure scenario: REF_DEPTH=2, rx_valid held at 0 -> after 2 frames, tx_valid stays 0 and frames_sent=2; after one rx frame completes, the third frame starts.
REQ-027 Unreferenced-frame scenario: drive 51 rx_valid bits with no tx activity -> frames_bad=1, ref_underflow=1, frame_pass=0.
REQ-028 Mid-operation reset scenario: assert rst at tx bit 20 of frame 1, then rerun loopback -> the first tx bits equal those of the first run, and all counters restart from 0.
REQ-029 Saturation scenario: CNT_WIDTH=2, 5 frames each with 1 error -> frames_bad=3 and bit_errors=3.
